// File: rtl/scan_down_counter_pkg.sv
// Shared types and constants for the scan-testable down counter.
package scan_down_counter_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/scan_dff.sv
// Mux-D scan flop: captures si_i when se_i is high, otherwise d_i.
module scan_dff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    input  logic si_i,
    input  logic se_i,
    output logic q_o
);

    // Scan-muxed storage bit with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= 1'b0;
        end else begin
            q_o <= se_i ? si_i : d_i;
        end
    end

endmodule

// File: rtl/scan_down_counter.sv
// Loadable down counter with one-shot/auto-reload modes and a scan chain on the count bits.
// Scan shifting is only active when SCAN_DOWN_COUNTER_SCAN_EN is defined.
module scan_down_counter
    import scan_down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             reload_mode,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             scan_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic [WIDTH-1:0] scan_si_s;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
    logic             scan_se_s;

    // Bit i shifts in from bit i+1; the MSB takes scan_in, the LSB leaves on scan_out.
    assign scan_si_s = {scan_in, count_q[WIDTH-1:1]};

`ifdef SCAN_DOWN_COUNTER_SCAN_EN
    assign scan_se_s = scan_en;
    assign scan_out  = count_q[0];
`else
    logic unused_scan_en_s;
    assign unused_scan_en_s = scan_en;
    assign scan_se_s        = 1'b0;
    assign scan_out         = 1'b0;
`endif

    // Next-state decode: scan > load > en > hold.
    always_comb begin
        count_d = count_q;
        rld_d   = rld_q;
        state_d = state_q;
        tc_d    = 1'b0;
        if (scan_se_s) begin
            // count bits take the scan path inside scan_dff; everything else holds
            tc_d = 1'b0;
        end else if (load) begin
            count_d = load_val;
            rld_d   = load_val;
            state_d = (load_val != WIDTH'(0)) ? RUN : IDLE;
        end else if ((state_q == RUN) && en) begin
            if (count_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (reload_mode) begin
                    count_d = rld_q;
                end else begin
                    count_d = WIDTH'(0);
                    state_d = DONE;
                end
            end else if (count_q != WIDTH'(0)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            tc_d = 1'b0;
        end
    end

    // Count register built from scan flops, one per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_count_bit
        scan_dff u_bit (
            .clk_i  (clk),
            .rst_n_i(rst_n),
            .d_i    (count_d[i]),
            .si_i   (scan_si_s[i]),
            .se_i   (scan_se_s),
            .q_o    (count_q[i])
        );
    end

    // FSM state, reload value and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rld_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_scan_down_counter.sv
// Self-checking bench for scan_down_counter: directed vector table, reset/scan sequences, random vs. model.
module tb_scan_down_counter;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         reload_mode;
    logic         scan_en;
    logic         scan_in;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
    logic         scan_out;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: phase 0 = waiting for load, 1 = counting, 2 = finished
    int m_count, m_rld, m_phase, m_tc;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       e;
        logic       rm;
        int         c;
        int         t;
        int         b;
        int         d;
    } vec_t;

    vec_t vecs[21];

    scan_down_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .reload_mode(reload_mode),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done),
        .scan_out   (scan_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic l, input logic [3:0] lv, input logic e,
                         input logic rm, input logic se, input logic si);
        load        = l;
        load_val    = lv;
        en          = e;
        reload_mode = rm;
        scan_en     = se;
        scan_in     = si;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit scan_active(input logic se);
`ifdef SCAN_DOWN_COUNTER_SCAN_EN
        return se;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        if (scan_active(scan_en)) begin
            m_count = (m_count / 2) + (scan_in ? (1 << (W - 1)) : 0);
            m_tc    = 0;
        end else if (load) begin
            m_count = load_val;
            m_rld   = load_val;
            m_phase = (load_val != 0) ? 1 : 0;
            m_tc    = 0;
        end else if (m_phase == 1 && en && m_count == 1) begin
            m_tc = 1;
            if (reload_mode) begin
                m_count = m_rld;
            end else begin
                m_count = 0;
                m_phase = 2;
            end
        end else begin
            if (m_phase == 1 && en && m_count > 1) m_count = m_count - 1;
            m_tc = 0;
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        m_count = 0; m_rld = 0; m_phase = 0; m_tc = 0;
        step();
    endtask

    initial begin
        int exp_so[4];
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = '{1'b1, 4'd3,  1'b1, 1'b0, 3,  0, 1, 0};
        vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 2,  0, 1, 0};
        vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1,  0, 1, 0};
        vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0,  1, 0, 1};
        vecs[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0,  0, 0, 1};
        vecs[5]  = '{1'b1, 4'd2,  1'b1, 1'b1, 2,  0, 1, 0};
        vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1,  0, 1, 0};
        vecs[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 2,  1, 1, 0};
        vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1,  0, 1, 0};
        vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 2,  1, 1, 0};
        vecs[10] = '{1'b0, 4'd0,  1'b0, 1'b1, 2,  0, 1, 0};
        vecs[11] = '{1'b1, 4'd5,  1'b1, 1'b0, 5,  0, 1, 0};
        vecs[12] = '{1'b1, 4'd9,  1'b1, 1'b0, 9,  0, 1, 0};
        vecs[13] = '{1'b1, 4'd0,  1'b1, 1'b0, 0,  0, 0, 0};
        vecs[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 0,  0, 0, 0};
        vecs[15] = '{1'b1, 4'd1,  1'b0, 1'b1, 1,  0, 1, 0};
        vecs[16] = '{1'b0, 4'd0,  1'b1, 1'b1, 1,  1, 1, 0};
        vecs[17] = '{1'b0, 4'd0,  1'b1, 1'b1, 1,  1, 1, 0};
        vecs[18] = '{1'b0, 4'd0,  1'b1, 1'b0, 0,  1, 0, 1};
        vecs[19] = '{1'b1, 4'd15, 1'b0, 1'b0, 15, 0, 1, 0};
        vecs[20] = '{1'b0, 4'd0,  1'b1, 1'b0, 14, 0, 1, 0};

        // reset state
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_scan_out", int'(scan_out), 0);
        rst_n = 1'b1;
        step();

        // directed vector table
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].rm, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].c);
            chk($sformatf("vec%0d_tc", i), int'(tc), vecs[i].t);
            chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].b);
            chk($sformatf("vec%0d_done", i), int'(done), vecs[i].d);
        end

        // asynchronous reset in the middle of a run
        drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("midrst_pre_count", int'(count), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tc", int'(tc), 0);
        chk("midrst_scan_out", int'(scan_out), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("postrst_count", int'(count), 0);
            chk("postrst_busy", int'(busy), 0);
            chk("postrst_tc", int'(tc), 0);
        end

        // scan shift of 4'b1010 with scan_in held high
        drive(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("scan_pre_count", int'(count), 10);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef SCAN_DOWN_COUNTER_SCAN_EN
        exp_so = '{0, 1, 0, 1};
`else
        exp_so = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("scan_out_%0d", k), int'(scan_out), exp_so[k]);
            step();
            chk($sformatf("scan_tc_%0d", k), int'(tc), 0);
        end
`ifdef SCAN_DOWN_COUNTER_SCAN_EN
        chk("scan_final_count", int'(count), 15);
`else
        chk("scan_final_count", int'(count), 10);
        chk("scan_out_after", int'(scan_out), 0);
`endif
        chk("scan_busy", int'(busy), 1);
        chk("scan_done", int'(done), 0);

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            if (($urandom_range(0, 15) == 0) && !scan_en) load_val = 4'($urandom);
            model_step();
            step();
            chk("rnd_count", int'(count), m_count);
            chk("rnd_tc", int'(tc), m_tc);
            chk("rnd_busy", int'(busy), (m_phase == 1) ? 1 : 0);
            chk("rnd_done", int'(done), (m_phase == 2) ? 1 : 0);
`ifdef SCAN_DOWN_COUNTER_SCAN_EN
            chk("rnd_scan_out", int'(scan_out), m_count % 2);
`else
            chk("rnd_scan_out", int'(scan_out), 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
